buzzer_arbiter: RTL

Owns the single piezo buzzer output and shares it between the lock controller's event sources: key click, unlock success, and wrong-code/lockout failure. Each source issues a one-cycle request. The arbiter grants by fixed priority, lets higher-priority events preempt, and queues lower-priority ones. For each granted event it plays a parameterised tone pattern (square-wave half-period, total duration, optional mute window), then inserts a silent gap before serving the next event.

---
 rtl/buz_pkg.sv | 58 +++++
 rtl/tone_gen.sv | 49 ++++
 rtl/buzzer_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/buz_pkg.sv
// Shared definitions for the buzzer arbiter: source codes, FSM states, pattern lookup.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package buzz_pkg;

   // Source codes double as priority values: a larger code means a higher priority.
   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_KEY  = 2'd1;
   localparam logic [1:0] SRC_OK   = 2'd2;
   localparam logic [1:0] SRC_FAIL = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] half;
      logic [31:0] dur;
   } pat_t;

   // Tone half-period and pattern length for a source. SRC_NONE falls back to the
   // key pattern; callers only use the result while a real source is selected.
   function automatic pat_t pat_of(input logic [1:0]  src,
                                   input logic [31:0] key_half,
                                   input logic [31:0] key_dur,
                                   input logic [31:0] ok_half,
                                   input logic [31:0] ok_dur,
                                   input logic [31:0] fail_half,
                                   input logic [31:0] fail_dur);
      pat_t p;
      case (src)
         SRC_OK: begin
            p.half = ok_half;
            p.dur  = ok_dur;
         end
         SRC_FAIL: begin
            p.half = fail_half;
            p.dur  = fail_dur;
         end
         default: begin
            p.half = key_half;
            p.dur  = key_dur;
         end
      endcase
      return p;
   endfunction

   // Highest-priority source in a request vector; bit index equals the source code.
   function automatic logic [1:0] top_src(input logic [3:1] v);
      if (v[3]) return SRC_FAIL;
      if (v[2]) return SRC_OK;
      if (v[1]) return SRC_KEY;
      return SRC_NONE;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: level toggles every half_i enabled cycles, restart forces phase high.
// Latency: tone_next_o is the level the register takes at the next edge (combinational look-ahead).
// Backpressure: none; en_i simply freezes the phase.
//   clk, rst      : clock, synchronous active-high reset
//   restart_i     : start a fresh period (level 1, counter 0)
//   en_i          : advance the toggle counter this cycle
//   half_i        : half-period in cycles (>=1)
//   tone_next_o   : next tone level
module tone_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        restart_i,
   input  logic        en_i,
   input  logic [31:0] half_i,
   output logic        tone_next_o
);

   logic [31:0] cnt_q, cnt_d;
   logic        tone_q, tone_d;

   always_comb begin
      cnt_d  = cnt_q;
      tone_d = tone_q;
      if (restart_i) begin
         cnt_d  = 32'd0;
         tone_d = 1'b1;
      end else if (en_i) begin
         if (cnt_q == half_i - 32'd1) begin
            cnt_d  = 32'd0;
            tone_d = ~tone_q;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= 32'd0;
         tone_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tone_q <= tone_d;
      end
   end

   assign tone_next_o = tone_d;

endmodule

// File: rtl/buzzer_arbiter.sv
// Shares one piezo buzzer between key/ok/fail events: fixed priority, preemption, queued pending bits.
// Latency: request to buzzer high in one edge; silent gap of GAP_CYCLES between patterns.
// Backpressure: none; requests that cannot play now are held as one pending bit per source.
//   clk, rst                   : clock, synchronous active-high reset
//   req_key, req_ok, req_fail  : one-cycle event requests
//   mute                       : level, silences the buzzer without affecting sequencing
//   buzzer                     : registered square-wave drive
//   busy, active_src, done     : status; done pulses when a pattern completes naturally
module buzzer_arbiter
   import buzz_pkg::*;
#(
   parameter int unsigned KEY_HALF        = 50000,
   parameter int unsigned KEY_DUR         = 10000000,
   parameter int unsigned OK_HALF         = 25000,
   parameter int unsigned OK_DUR          = 30000000,
   parameter int unsigned FAIL_HALF       = 100000,
   parameter int unsigned FAIL_DUR        = 15000000,
   parameter int unsigned FAIL_MUTE_START = 5000000,
   parameter int unsigned FAIL_MUTE_END   = 10000000,
   parameter int unsigned GAP_CYCLES      = 2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_key,
   input  logic       req_ok,
   input  logic       req_fail,
   input  logic       mute,
   output logic       buzzer,
   output logic       busy,
   output logic [1:0] active_src,
   output logic       done
);

   localparam logic [31:0] MUTE_S = 32'(FAIL_MUTE_START);
   localparam logic [31:0] MUTE_E = 32'(FAIL_MUTE_END);
   localparam logic [31:0] GAP_N  = 32'(GAP_CYCLES);

   state_t      state_q, state_d;
   logic [1:0]  src_q, src_d;
   logic [31:0] dur_cnt_q, dur_cnt_d;
   logic [31:0] gap_cnt_q, gap_cnt_d;
   logic [3:1]  pend_q, pend_d;
   logic        buzzer_q, buzzer_d;
   logic        done_q, done_d;

   logic [3:1]  req_v;
   logic [1:0]  req_top, any_top, grant;
   logic        dur_end, in_win, tone_next;
   pat_t        cur;

   assign req_v   = {req_fail, req_ok, req_key};
   assign req_top = top_src(req_v);
   assign any_top = top_src(pend_q | req_v);
   assign cur     = pat_of(src_q, 32'(KEY_HALF), 32'(KEY_DUR), 32'(OK_HALF), 32'(OK_DUR),
                           32'(FAIL_HALF), 32'(FAIL_DUR));
   assign dur_end = (dur_cnt_q == cur.dur - 32'd1);

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dur_cnt_d = dur_cnt_q;
      gap_cnt_d = gap_cnt_q;
      pend_d    = pend_q | req_v;
      done_d    = 1'b0;
      grant     = SRC_NONE;
      case (state_q)
         IDLE: grant = any_top;
         PLAY: begin
            // Higher priority always preempts; equal priority retriggers, except on the
            // final cycle where the ending pattern completes and the request waits.
            if (req_top != SRC_NONE && (req_top > src_q || (req_top == src_q && !dur_end))) begin
               grant = req_top;
            end else if (dur_end) begin
               state_d   = GAP;
               gap_cnt_d = 32'd0;
               done_d    = 1'b1;
            end else begin
               dur_cnt_d = dur_cnt_q + 32'd1;
            end
         end
         GAP: begin
            // A request on the last gap cycle competes alongside the pending bits.
            if (gap_cnt_q == GAP_N - 32'd1) begin
               grant = any_top;
               if (any_top == SRC_NONE) begin
                  state_d = IDLE;
                  src_d   = SRC_NONE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (grant != SRC_NONE) begin
         state_d   = PLAY;
         src_d     = grant;
         dur_cnt_d = 32'd0;
         for (int s = 1; s <= 3; s++) begin
            if (grant == 2'(s)) pend_d[s] = 1'b0;
         end
      end
   end

   // Silent window is judged on the next count so buzzer_q lines up with dur_cnt_q.
   assign in_win   = (src_d == SRC_FAIL) && (dur_cnt_d >= MUTE_S) && (dur_cnt_d < MUTE_E);
   assign buzzer_d = (state_d == PLAY) && tone_next && !mute && !in_win;

   tone_gen u_tone (
      .clk         (clk),
      .rst         (rst),
      .restart_i   (grant != SRC_NONE),
      .en_i        (state_q == PLAY),
      .half_i      (cur.half),
      .tone_next_o (tone_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         src_q     <= SRC_NONE;
         dur_cnt_q <= 32'd0;
         gap_cnt_q <= 32'd0;
         pend_q    <= 3'b000;
         buzzer_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dur_cnt_q <= dur_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         pend_q    <= pend_d;
         buzzer_q  <= buzzer_d;
         done_q    <= done_d;
      end
   end

   assign buzzer     = buzzer_q;
   assign busy       = (state_q != IDLE);
   assign active_src = src_q;
   assign done       = done_q;

endmodule
